// File: rtl/seg7_mux_driver.sv
// Multiplexed common-anode 7-segment driver with frame-synchronous double buffer.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module seg7_mux_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [4*NUM_DIGITS-1:0] BIN_IN,
  input  logic [NUM_DIGITS-1:0]   DOT_IN,
  input  logic [NUM_DIGITS-1:0]   DIGIT_EN,
  input  logic                    LOAD,
  output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
  output logic [7:0]              HEX_OUT,
  output logic                    FRAME_TICK
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_TC  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [4*NUM_DIGITS-1:0]   pend_bin, act_bin;
  logic [NUM_DIGITS-1:0]     pend_dot, act_dot;
  logic [NUM_DIGITS-1:0]     pend_en, act_en;

  logic                      slot_end, frame_bnd;
  logic [3:0]                cur_nib;
  logic                      cur_dot, cur_en, cur_sup;
  logic [NUM_DIGITS-1:0]     cur_sel;
  logic [NUM_DIGITS-1:0]     lz_run;
  logic [6:0]                seg;
  logic [NUM_DIGITS-1:0]     sel_d;
  logic [7:0]                hex_d;

  assign slot_end  = (cnt == CNT_TC);
  assign frame_bnd = slot_end && (idx == IDX_LAST);

  // lz_run[k]: digits k..top are all zero with no dot
  always_comb begin
    lz_run = '0;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_run[NUM_DIGITS-1] =
      (act_bin[4*NUM_DIGITS-1 -: 4] == 4'h0) && !act_dot[NUM_DIGITS-1];
    for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
      lz_run[k] = (act_bin[4*k +: 4] == 4'h0) && !act_dot[k]
                  && lz_run[k+1];
    end
`endif
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dot = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    cur_sel = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib    = act_bin[4*k +: 4];
        cur_dot    = act_dot[k];
        cur_en     = act_en[k];
        cur_sup    = (k != 0) && lz_run[k];
        cur_sel[k] = 1'b0;
      end
    end
  end

  always_comb begin
    seg = 7'h7F;
    unique case (cur_nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

  always_comb begin
    sel_d = '1;
    hex_d = 8'hFF;
    if ((cnt >= BLANK_C) && cur_en && !cur_sup) begin
      sel_d = cur_sel;
      hex_d = {~cur_dot, seg};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt            <= '0;
      idx            <= '0;
      pend_bin       <= '0;
      pend_dot       <= '0;
      pend_en        <= '0;
      act_bin        <= '0;
      act_dot        <= '0;
      act_en         <= '0;
      SEG_SELECT_OUT <= '1;
      HEX_OUT        <= 8'hFF;
      FRAME_TICK     <= 1'b0;
    end else begin
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (LOAD) begin
        pend_bin <= BIN_IN;
        pend_dot <= DOT_IN;
        pend_en  <= DIGIT_EN;
      end
      // A load landing on the boundary bypasses straight to the display
      if (frame_bnd) begin
        act_bin <= LOAD ? BIN_IN   : pend_bin;
        act_dot <= LOAD ? DOT_IN   : pend_dot;
        act_en  <= LOAD ? DIGIT_EN : pend_en;
      end
      SEG_SELECT_OUT <= sel_d;
      HEX_OUT        <= hex_d;
      FRAME_TICK     <= frame_bnd;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Randomized self-checking bench for seg7_mux_driver (4 digits, div 4, blank 1).
// A time-indexed model derives slot, digit and frame from the cycle count.
module tb_seg7_mux_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int BC = 1;
  localparam int FR = ND * RD;

  logic        CLK;
  logic        RESET;
  logic [15:0] BIN_IN;
  logic [3:0]  DOT_IN;
  logic [3:0]  DIGIT_EN;
  logic        LOAD;
  logic [3:0]  SEG_SELECT_OUT;
  logic [7:0]  HEX_OUT;
  logic        FRAME_TICK;

  seg7_mux_driver #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BIN_IN        (BIN_IN),
    .DOT_IN        (DOT_IN),
    .DIGIT_EN      (DIGIT_EN),
    .LOAD          (LOAD),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .HEX_OUT       (HEX_OUT),
    .FRAME_TICK    (FRAME_TICK)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [7:0] seg_tbl [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int checks = 0;
  int failures = 0;
  int t = 0;
  logic [15:0] pb, ab;
  logic [3:0]  pd, ad, pe, ae;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_hex;
  logic        exp_tick;

  function automatic bit suppressed(int i);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    return (i > 0) && ((ab >> (4 * i)) == 16'h0) && ((ad >> i) == 4'h0);
`else
    return (i < 0);
`endif
  endfunction

  // Advance one clock: predict outputs from the current model state, then update it.
  task automatic cyc();
    int c, i;
    bit bnd, show;
    if (RESET) begin
      exp_sel = 4'hF; exp_hex = 8'hFF; exp_tick = 1'b0;
      t = 0; pb = '0; ab = '0; pd = '0; ad = '0; pe = '0; ae = '0;
    end else begin
      c = t % RD;
      i = (t / RD) % ND;
      bnd = (t % FR) == FR - 1;
      show = (c >= BC) && ae[i] && !suppressed(i);
      exp_sel = show ? ~(4'b0001 << i) : 4'hF;
      exp_hex = show ? (seg_tbl[(ab >> (4 * i)) & 16'hF] & (ad[i] ? 8'h7F : 8'hFF))
                     : 8'hFF;
      exp_tick = bnd;
      if (bnd) begin
        ab = LOAD ? BIN_IN : pb;
        ad = LOAD ? DOT_IN : pd;
        ae = LOAD ? DIGIT_EN : pe;
      end
      if (LOAD) begin pb = BIN_IN; pd = DOT_IN; pe = DIGIT_EN; end
      t++;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(logic [15:0] b, logic [3:0] d, logic [3:0] e);
    BIN_IN = b; DOT_IN = d; DIGIT_EN = e; LOAD = 1'b1;
    cyc();
    LOAD = 1'b0;
  endtask

  task automatic test_reset();
    int ticks;
    RESET = 1'b1;
    cyc();
    cyc();
    checks++;
    if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL reset got sel=%b hex=%h tick=%b need 1111/ff/0",
               SEG_SELECT_OUT, HEX_OUT, FRAME_TICK);
    end
    RESET = 1'b0;
    ticks = 0;
    for (int k = 0; k < 32; k++) begin
      cyc();
      ticks += FRAME_TICK;
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL idle t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
    checks++;
    if (ticks != 2) begin
      failures++;
      $display("FAIL tick_count got %0d need 2", ticks);
    end
  endtask

  task automatic test_load_sync();
    for (int k = 0; k < 5; k++) cyc();
    do_load(16'h3210, 4'h0, 4'hF);
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL load_sync t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
  endtask

  task automatic test_dots();
    bit saw40, saw80;
    saw40 = 0; saw80 = 0;
    do_load(16'h0008, 4'b0100, 4'hF);
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (HEX_OUT == 8'h40 && SEG_SELECT_OUT == 4'b1011) saw40 = 1;
      if (HEX_OUT == 8'h80 && SEG_SELECT_OUT == 4'b1110) saw80 = 1;
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL dots t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
    checks++;
    if (!(saw40 && saw80)) begin
      failures++;
      $display("FAIL dots_seen got d2=%0d d0=%0d need 1 1", saw40, saw80);
    end
  endtask

  task automatic test_digit_en();
    do_load(16'h4321, 4'h0, 4'b0101);
    for (int k = 0; k < 40; k++) begin
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL digit_en t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
  endtask

  task automatic test_boundary_load();
    for (int k = 0; k < FR && (t % FR) != FR - 1; k++) cyc();
    do_load(16'hFFFF, 4'h0, 4'hF);
    for (int k = 0; k < FR; k++) begin
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL bypass t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
    do_load(16'(($urandom % 16'hFFFF)), 4'($urandom), 4'hF);
    for (int k = 0; k < 2 * FR; k++) begin
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL deferred t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      BIN_IN = 16'($urandom);
      DOT_IN = 4'($urandom);
      DIGIT_EN = 4'($urandom);
      if ((k % 3) == 0) BIN_IN = BIN_IN & 16'h00F0;
      LOAD = ($urandom % 6) == 0;
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL random t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
      checks++;
      if ($countones(~SEG_SELECT_OUT) > 1) begin
        failures++;
        $display("FAIL one_hot got sel=%b need at most one low", SEG_SELECT_OUT);
      end
    end
    LOAD = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_load(16'hABCD, 4'hF, 4'hF);
    for (int k = 0; k < 2 * FR && !(((t / RD) % ND) == 2 && (t % RD) == 2); k++)
      cyc();
    RESET = 1'b1;
    cyc();
    checks++;
    if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {4'hF, 8'hFF, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got %b/%h/%b need 1111/ff/0",
               SEG_SELECT_OUT, HEX_OUT, FRAME_TICK);
    end
    RESET = 1'b0;
    BIN_IN = 16'h0050; DOT_IN = 4'h0; DIGIT_EN = 4'hF;
    for (int k = 0; k < 3 * FR; k++) begin
      LOAD = (k == 3);
      cyc();
      checks++;
      if ({SEG_SELECT_OUT, HEX_OUT, FRAME_TICK} !== {exp_sel, exp_hex, exp_tick}) begin
        failures++;
        $display("FAIL after_reset t=%0d got %b/%h/%b need %b/%h/%b", t,
                 SEG_SELECT_OUT, HEX_OUT, FRAME_TICK, exp_sel, exp_hex, exp_tick);
      end
    end
    LOAD = 1'b0;
  endtask

  initial begin
    RESET = 1'b1;
    LOAD = 1'b0;
    BIN_IN = '0;
    DOT_IN = '0;
    DIGIT_EN = '0;
    test_reset();
    test_load_sync();
    test_dots();
    test_digit_en();
    test_boundary_load();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
